// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
//
// Per-note attack/decay/sustain/release amplitude envelope. It multiplies the
// signed oscillator sample by the current envelope level and produces one
// shaped sample per 48 kHz clock.
//
// Ports
//   clk_48kHz        sample clock; all state updates on the rising edge
//   rst_n            asynchronous, active-low reset
//   gate_i           note on (1) / off (0); edges are detected internally
//   sample_i         signed DATA_W-bit oscillator sample
//   attack_step_i    per-cycle envelope increment in ATTACK (0 = instant)
//   decay_step_i     per-cycle envelope decrement in DECAY (0 = instant)
//   sustain_level_i  envelope level held in SUSTAIN
//   release_step_i   per-cycle envelope decrement in RELEASE (0 = instant)
//   sample_o         registered enveloped sample (1-cycle latency)
//   env_o            current envelope level (register)
//   state_o          FSM state: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active_o         1 whenever the FSM is not IDLE (register)
// -----------------------------------------------------------------------------
module adsr_envelope #(
    parameter int DATA_W = 24,
    parameter int ENV_W  = 16
) (
    input  logic                     clk_48kHz,
    input  logic                     rst_n,
    input  logic                     gate_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic        [ENV_W-1:0]  attack_step_i,
    input  logic        [ENV_W-1:0]  decay_step_i,
    input  logic        [ENV_W-1:0]  sustain_level_i,
    input  logic        [ENV_W-1:0]  release_step_i,
    output logic signed [DATA_W-1:0] sample_o,
    output logic        [ENV_W-1:0]  env_o,
    output logic        [2:0]        state_o,
    output logic                     active_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    localparam int               PROD_W  = DATA_W + ENV_W + 1;

    state_t             state_q;
    state_t             state_n;
    logic [ENV_W-1:0]   env_q;
    logic [ENV_W-1:0]   env_n;
    logic               gate_q;
    logic               active_q;

    logic               rise;
    logic               fall;
    logic [ENV_W:0]     attack_sum;
    logic signed [ENV_W:0] decay_diff;

    logic signed [PROD_W-1:0] samp_ext;
    logic signed [PROD_W-1:0] env_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     unused_prod_bits;

    assign rise = gate_i & ~gate_q;
    assign fall = ~gate_i & gate_q;

    // 17-bit sum so the attack overshoot past full scale is visible.
    assign attack_sum = {1'b0, env_q} + {1'b0, attack_step_i};

    // Signed 17-bit difference: a step larger than the level goes negative
    // instead of wrapping, so the sustain compare stays correct.
    assign decay_diff = $signed({1'b0, env_q}) - $signed({1'b0, decay_step_i});

    // Envelope is an unsigned gain below 1.0; zero-extend it to a positive
    // signed operand and multiply at full width so nothing is lost before
    // the shift.
    assign samp_ext = {{(ENV_W + 1){sample_i[DATA_W-1]}}, sample_i};
    assign env_ext  = {{(DATA_W + 1){1'b0}}, env_q};
    assign prod     = samp_ext * env_ext;

    // Discarded fraction bits and the always-redundant sign bit of the product.
    assign unused_prod_bits = ^{prod[ENV_W-1:0], prod[PROD_W-1]};

    // Next-state / next-envelope. Gate edges take priority over the
    // per-state action: rise first, then fall, then the normal step.
    always_comb begin
        state_n = state_q;
        env_n   = env_q;
        if (rise) begin
            // Retrigger from the current level so there is no click.
            state_n = ATTACK;
        end else if (fall && (state_q == ATTACK || state_q == DECAY ||
                              state_q == SUSTAIN)) begin
            state_n = RELEASE;
        end else begin
            case (state_q)
                IDLE: begin
                    env_n = '0;
                end
                ATTACK: begin
                    if (attack_step_i == '0 || attack_sum >= {1'b0, ENV_MAX}) begin
                        env_n   = ENV_MAX;
                        state_n = DECAY;
                    end else begin
                        env_n = attack_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    if (decay_step_i == '0 ||
                        decay_diff <= $signed({1'b0, sustain_level_i})) begin
                        env_n   = sustain_level_i;
                        state_n = SUSTAIN;
                    end else begin
                        env_n = decay_diff[ENV_W-1:0];
                    end
                end
                SUSTAIN: begin
                    // Track live sustain changes one cycle later.
                    env_n = sustain_level_i;
                end
                RELEASE: begin
                    if (release_step_i == '0 || env_q <= release_step_i) begin
                        env_n   = '0;
                        state_n = IDLE;
                    end else begin
                        env_n = env_q - release_step_i;
                    end
                end
                default: begin
                    env_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_48kHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            env_q    <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
            sample_o <= '0;
        end else begin
            gate_q   <= gate_i;
            state_q  <= state_n;
            env_q    <= env_n;
            active_q <= (state_n != IDLE);
            // Arithmetic shift right by ENV_W (rounds toward -inf); the
            // result always fits in DATA_W because env < 2^ENV_W.
            sample_o <= prod[ENV_W +: DATA_W];
        end
    end

    assign env_o    = env_q;
    assign state_o  = state_q;
    assign active_o = active_q;

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-note amplitude envelope (attack/decay/sustain/release) applied to the signed 24-bit oscillator output.
- Sits directly downstream of the waveform generator. It takes `out_sig_o` as `sample_i` and produces the shaped sample that feeds the audio output / WAV capture path.
- One sample per clock; the clock is the 48 kHz sample clock.
- Keypad press/release drives `gate_i`.

Parameters:
- DATA_W, 24, sample width (signed two's complement).
- ENV_W, 16, envelope level width (unsigned; full scale = 2^ENV_W-1 = 65535).

Ports:
- clk_48kHz  input  1  sample clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gate_i  input  1  note on (1) / note off (0); level-sensitive, edges detected internally.
- sample_i  input  DATA_W  signed oscillator sample.
- attack_step_i  input  ENV_W  per-cycle envelope increment in ATTACK; 0 = instant.
- decay_step_i  input  ENV_W  per-cycle decrement in DECAY; 0 = instant.
- sustain_level_i  input  ENV_W  sustain envelope level.
- release_step_i  input  ENV_W  per-cycle decrement in RELEASE; 0 = instant.
- sample_o  output  DATA_W  signed enveloped sample, registered.
- env_o  output  ENV_W  current envelope level (env_q).
- state_o  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active_o  output  1  1 when state != IDLE.

Behaviour:
- Reset (async assert, sync release on next edge):
  - state=IDLE, env_q=0, gate_q=0, sample_o=0, active_o=0.
  - Reset mid-note forces all outputs to these values immediately.
- Edge detect:
  - gate_q <= gate_i each cycle.
  - rise = gate_i & ~gate_q; fall = ~gate_i & gate_q.
  - With gate held high through reset release, a rise is detected on the first edge.
- Priority each edge: rise, then fall, then the normal state action.
- rise (any state, including RELEASE or ATTACK retrigger):
  - state <= ATTACK; env_q keeps its current value (no reset to 0, no click).
  - The ATTACK increment starts on the next edge.
- fall in ATTACK/DECAY/SUSTAIN:
  - state <= RELEASE; env_q held this cycle.
  - fall in IDLE/RELEASE: no effect.
- ATTACK:
  - If attack_step_i==0 or env_q+attack_step_i >= 65535 (17-bit compare): env_q <= 65535, state <= DECAY.
  - Else env_q <= env_q+attack_step_i.
- DECAY:
  - If decay_step_i==0 or env_q-decay_step_i <= sustain_level_i (signed 17-bit compare, no underflow): env_q <= sustain_level_i, state <= SUSTAIN.
  - Else env_q <= env_q-decay_step_i.
- SUSTAIN: env_q <= sustain_level_i every cycle, so live changes track with 1-cycle delay. Stays until fall.
- RELEASE:
  - If release_step_i==0 or env_q <= release_step_i: env_q <= 0, state <= IDLE.
  - Else env_q <= env_q-release_step_i.
- IDLE: env_q holds 0.
- Output arithmetic:
  - prod = sample_i * signed({1'b0,env_q}), computed at full width (DATA_W+ENV_W+1 = 41 bits).
  - sample_o <= prod >>> ENV_W, truncated to DATA_W (arithmetic shift; rounds toward -inf). Cannot overflow, since |env| < 2^16.
  - sample_o at edge k uses sample_i at edge k and env_q before edge k's update: 1-cycle latency.
- env_o, state_o and active_o are direct register outputs.

Test Plan:
- Attack: steps attack=4096, decay=1024, sustain=32768, release=2048; reset, gate_i=1 -> env_o = 4096·n during ATTACK; env_o=65535 and state_o=DECAY after edge 17 (rise edge + 16 steps).
- Decay/sustain, same settings -> env_o reaches 32768 with state_o=SUSTAIN 32 edges after DECAY entry (65535-32·1024=32767 clamps). Then sustain_level_i=20000 -> env_o=20000 next edge.
- Output math: env held at 32768 -> sample_i=8388607 gives sample_o=4194303; sample_i=-8388608 gives -4194304; env 0 gives 0. Each appears one edge after the input is applied.
- Release from 32768 at step 2048 -> env_o reaches 0 and state_o=IDLE, active_o=0 after 16 RELEASE edges. Gate re-rise at env=16384 mid-release -> ATTACK resumes from 16384 (next env_o 20480).
- Instant steps: all step inputs 0, pulse gate high 3 cycles -> ATTACK→DECAY→SUSTAIN on consecutive edges (env 65535 then sustain). Fall -> RELEASE then IDLE with env 0 on the next edge.
- Reset mid-ATTACK (env ~30000) -> sample_o, env_o, state_o go to 0 asynchronously before the next clock edge. Gate held high through reset release -> new ATTACK from 0.
